serial_cubestate_rx: RTL and testbench

//  UART 8N1 receiver paired with the serial cubestate transmitter. Receives a 162-bit cubestate

---
 rtl/serial_cubestate_rx_pkg.sv | 10 +
 rtl/uart_rx_byte.sv | 60 ++++++
 rtl/serial_cubestate_rx.sv | 80 ++++++++
 tb/tb_serial_cubestate_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_cubestate_rx_pkg.sv
// serial_cubestate_rx_pkg: frame constants and state encodings shared by the cubestate serial link.
package serial_cubestate_rx_pkg;
  localparam int CUBESTATE_W = 162;
  localparam int PAYLOAD_BYTES = 21;
  localparam int PAD_BITS = 6;
  localparam int FRAME_W = CUBESTATE_W + PAD_BITS;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {WAIT_SYNC, PAYLOAD, CHECK} frame_state_t;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with input synchroniser, mid-bit sampling and stop-bit check.
module uart_rx_byte import serial_cubestate_rx_pkg::*; #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       byte_strobe,
  output logic       byte_err
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] sync;
  logic rxs;
  byte_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  assign rxs = sync[1];
  always_ff @(posedge clock) begin
    byte_strobe <= 1'b0;
    byte_err <= 1'b0;
    if (reset) begin
      sync <= 2'b11;
      state <= B_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
    end else begin
      sync <= {sync[0], rx_pin};
      case (state)
        B_IDLE: if (!rxs) begin
          state <= B_START;
          cnt <= '0;
          bit_idx <= '0;
        end
        B_START: if (cnt == HALF) begin
          cnt <= '0;
          state <= rxs ? B_IDLE : B_DATA;
        end else cnt <= cnt + 1'b1;
        B_DATA: if (cnt == FULL) begin
          cnt <= '0;
          data <= {rxs, data[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= B_STOP;
        end else cnt <= cnt + 1'b1;
        B_STOP: if (cnt == FULL) begin
          // Leave at mid-stop so a start bit right behind it is caught.
          byte_strobe <= rxs;
          byte_err <= !rxs;
          state <= B_IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= B_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/serial_cubestate_rx.sv
// serial_cubestate_rx: receives a sync/payload/checksum cubestate frame over UART and publishes it.
module serial_cubestate_rx import serial_cubestate_rx_pkg::*; #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD = 115_200,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int TIMEOUT_CLKS = 250_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_pin,
  output logic [CUBESTATE_W-1:0] cubestate,
  output logic                   cubestate_valid,
  output logic                   frame_error,
  output logic                   checksum_error,
  output logic                   busy
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [4:0] LAST = 5'(PAYLOAD_BYTES - 1);
  logic [7:0] data;
  logic byte_strobe, byte_err;
  frame_state_t state;
  logic [FRAME_W-1:0] shreg;
  logic [7:0] chk;
  logic [4:0] idx;
  logic [TW-1:0] idle_cnt;
  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_byte (
    .clock(clock),
    .reset(reset),
    .rx_pin(rx_pin),
    .data(data),
    .byte_strobe(byte_strobe),
    .byte_err(byte_err)
  );
  assign busy = state != WAIT_SYNC;
  always_ff @(posedge clock) begin
    cubestate_valid <= 1'b0;
    frame_error <= 1'b0;
    checksum_error <= 1'b0;
    if (reset) begin
      state <= WAIT_SYNC;
      cubestate <= '0;
      shreg <= '0;
      chk <= '0;
      idx <= '0;
      idle_cnt <= '0;
    end else begin
      // Counts clocks elapsed since the last strobe, so the strobe cycle itself is 1.
      idle_cnt <= byte_strobe ? TW'(1) : busy ? idle_cnt + 1'b1 : '0;
      if (byte_err) begin
        frame_error <= busy;
        state <= WAIT_SYNC;
      end else if (byte_strobe) begin
        case (state)
          WAIT_SYNC: if (data == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx <= '0;
            chk <= '0;
          end
          PAYLOAD: begin
            shreg <= {shreg[FRAME_W-9:0], data};
            chk <= chk ^ data;
            idx <= idx + 5'd1;
            if (idx == LAST) state <= CHECK;
          end
          CHECK: begin
            if (data == chk && shreg[FRAME_W-1:CUBESTATE_W] == '0) begin
              cubestate <= shreg[CUBESTATE_W-1:0];
              cubestate_valid <= 1'b1;
            end else checksum_error <= 1'b1;
            state <= WAIT_SYNC;
          end
          default: state <= WAIT_SYNC;
        endcase
      end else if (busy && idle_cnt == TW'(TIMEOUT_CLKS - 1)) begin
        frame_error <= 1'b1;
        state <= WAIT_SYNC;
      end
    end
  end
endmodule

// File: tb/tb_serial_cubestate_rx.sv
// tb_serial_cubestate_rx: directed frames over a fast line rate with hand-derived pulse timing.
module tb_serial_cubestate_rx;
  import serial_cubestate_rx_pkg::*;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int CPB = CLK_HZ / BAUD;
  localparam int TMO = 1000;
  // Pin start of a byte -> stop mid-sample edge: 2 sync flops, 1 detect, half bit, 9 bits.
  localparam int STROBE_LAT = 3 + CPB / 2 + 9 * CPB;
  logic clock = 1'b0, reset = 1'b1, rx_pin = 1'b1;
  logic [CUBESTATE_W-1:0] cubestate;
  logic cubestate_valid, frame_error, checksum_error, busy;
  int vectors = 0, errors = 0;
  int cyc = 0, nvalid = 0, nferr = 0, ncerr = 0, vcyc = 0, fcyc = 0, ccyc = 0, busy_hi = 0, multi = 0;
  int last_start = 0;

  serial_cubestate_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .rx_pin(rx_pin),
    .cubestate(cubestate),
    .cubestate_valid(cubestate_valid),
    .frame_error(frame_error),
    .checksum_error(checksum_error),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (cubestate_valid) begin nvalid <= nvalid + 1; vcyc <= cyc; end
    if (frame_error) begin nferr <= nferr + 1; fcyc <= cyc; end
    if (checksum_error) begin ncerr <= ncerr + 1; ccyc <= cyc; end
    if (busy) busy_hi <= busy_hi + 1;
    if (int'(cubestate_valid) + int'(frame_error) + int'(checksum_error) > 1) multi <= multi + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    rx_pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(CPB);
    end
    rx_pin = stop;
    tick(CPB);
    rx_pin = 1'b1;
  endtask

  function automatic logic [FRAME_W-1:0] mk_word(input int kind);
    logic [FRAME_W-1:0] w;
    w = '0;
    for (int f = 0; f < 54; f++) w[3*f +: 3] = 3'((kind == 0) ? f / 9 : (f * 5 + kind) % 6);
    return w;
  endfunction

  task automatic send_frame(input logic [FRAME_W-1:0] w, input int flip);
    logic [7:0] c, b;
    c = '0;
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      b = w[FRAME_W-1-8*k -: 8];
      c ^= b;
      send_byte((k == flip) ? b ^ 8'h01 : b, 1'b1);
    end
    send_byte(c, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(4);
    vectors++; if (cubestate !== '0) begin errors++; $display("FAIL reset_cubestate: got %h expected 0", cubestate); end
    vectors++; if ({cubestate_valid, frame_error, checksum_error, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {cubestate_valid, frame_error, checksum_error, busy}); end
    reset = 1'b0;
    tick(2 * CPB);
  endtask

  task automatic test_solved;
    logic [FRAME_W-1:0] w;
    int v0, f0, c0;
    w = mk_word(0); v0 = nvalid; f0 = nferr; c0 = ncerr;
    send_frame(w, -1);
    tick(4);
    vectors++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL solved_valid_count: got %0d expected 1", nvalid - v0); end
    vectors++; if (vcyc !== last_start + STROBE_LAT + 1) begin
      errors++; $display("FAIL solved_latency: got cycle %0d expected %0d", vcyc, last_start + STROBE_LAT + 1); end
    vectors++; if (cubestate !== w[CUBESTATE_W-1:0]) begin
      errors++; $display("FAIL solved_state: got %h expected %h", cubestate, w[CUBESTATE_W-1:0]); end
    vectors++; if (nferr - f0 + ncerr - c0 !== 0) begin errors++; $display("FAIL solved_errors: got %0d expected 0", nferr - f0 + ncerr - c0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL solved_busy: got %b expected 0", busy); end
  endtask

  task automatic test_glitch;
    int v0, f0, c0, b0;
    v0 = nvalid; f0 = nferr; c0 = ncerr; b0 = busy_hi;
    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(4 * CPB);
    vectors++; if (nvalid - v0 + nferr - f0 + ncerr - c0 !== 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d expected 0", nvalid - v0 + nferr - f0 + ncerr - c0); end
    vectors++; if (busy_hi - b0 !== 0) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_hi - b0); end
  endtask

  task automatic test_bad_stop;
    logic [FRAME_W-1:0] w;
    int v0, f0;
    w = mk_word(1); v0 = nvalid; f0 = nferr;
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 7; k++) send_byte(w[FRAME_W-1-8*k -: 8], 1'b1);
    send_byte(w[FRAME_W-1-56 -: 8], 1'b0);
    tick(3 * CPB);
    vectors++; if (nferr - f0 !== 1) begin errors++; $display("FAIL badstop_count: got %0d expected 1", nferr - f0); end
    vectors++; if (fcyc !== last_start + STROBE_LAT + 1) begin
      errors++; $display("FAIL badstop_cycle: got %0d expected %0d", fcyc, last_start + STROBE_LAT + 1); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL badstop_busy: got %b expected 0", busy); end
    send_frame(w, -1);
    tick(4);
    vectors++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL badstop_recover_valid: got %0d expected 1", nvalid - v0); end
    vectors++; if (cubestate !== w[CUBESTATE_W-1:0]) begin
      errors++; $display("FAIL badstop_recover_state: got %h expected %h", cubestate, w[CUBESTATE_W-1:0]); end
  endtask

  task automatic test_checksum;
    logic [FRAME_W-1:0] w;
    logic [CUBESTATE_W-1:0] prev;
    int v0, c0;
    w = mk_word(3); prev = cubestate; v0 = nvalid; c0 = ncerr;
    send_frame(w, 12);
    tick(4);
    vectors++; if (ncerr - c0 !== 1) begin errors++; $display("FAIL chk_flip_count: got %0d expected 1", ncerr - c0); end
    vectors++; if (ccyc !== last_start + STROBE_LAT + 1) begin
      errors++; $display("FAIL chk_flip_cycle: got %0d expected %0d", ccyc, last_start + STROBE_LAT + 1); end
    vectors++; if (cubestate !== prev) begin errors++; $display("FAIL chk_flip_hold: got %h expected %h", cubestate, prev); end
    w[FRAME_W-1] = 1'b1;
    send_frame(w, -1);
    tick(4);
    vectors++; if (ncerr - c0 !== 2) begin errors++; $display("FAIL chk_pad_count: got %0d expected 2", ncerr - c0); end
    vectors++; if (cubestate !== prev) begin errors++; $display("FAIL chk_pad_hold: got %h expected %h", cubestate, prev); end
    vectors++; if (nvalid - v0 !== 0) begin errors++; $display("FAIL chk_no_valid: got %0d expected 0", nvalid - v0); end
  endtask

  task automatic test_timeout;
    logic [FRAME_W-1:0] w;
    int f0, v0, strobe;
    w = mk_word(2); f0 = nferr; v0 = nvalid;
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 10; k++) send_byte(w[FRAME_W-1-8*k -: 8], 1'b1);
    strobe = last_start + STROBE_LAT;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid: got %b expected 1", busy); end
    tick(TMO + 50);
    vectors++; if (nferr - f0 !== 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", nferr - f0); end
    vectors++; if (fcyc !== strobe + TMO) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", fcyc, strobe + TMO); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    send_frame(w, -1);
    tick(4);
    vectors++; if (nvalid - v0 !== 1 || cubestate !== w[CUBESTATE_W-1:0]) begin
      errors++; $display("FAIL timeout_restart: got %0d valid state %h expected 1 valid state %h", nvalid - v0, cubestate, w[CUBESTATE_W-1:0]); end
  endtask

  task automatic test_back_to_back;
    logic [FRAME_W-1:0] w1, w2;
    int v0, f0, c0;
    w1 = mk_word(4); w2 = mk_word(5); v0 = nvalid; f0 = nferr; c0 = ncerr;
    send_frame(w1, -1);
    send_frame(w2, -1);
    tick(4);
    vectors++; if (nvalid - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nvalid - v0); end
    vectors++; if (vcyc !== last_start + STROBE_LAT + 1) begin
      errors++; $display("FAIL b2b_latency: got %0d expected %0d", vcyc, last_start + STROBE_LAT + 1); end
    vectors++; if (cubestate !== w2[CUBESTATE_W-1:0]) begin
      errors++; $display("FAIL b2b_state: got %h expected %h", cubestate, w2[CUBESTATE_W-1:0]); end
    v0 = nvalid; f0 = nferr; c0 = ncerr;
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(w1[FRAME_W-1-8*k -: 8], 1'b1);
    rx_pin = 1'b0;
    tick(3 * CPB);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    rx_pin = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4 * CPB);
    vectors++; if (nvalid - v0 + nferr - f0 + ncerr - c0 !== 0) begin
      errors++; $display("FAIL midreset_pulses: got %0d expected 0", nvalid - v0 + nferr - f0 + ncerr - c0); end
    vectors++; if (busy !== 1'b0 || cubestate !== '0) begin
      errors++; $display("FAIL midreset_state: got busy %b state %h expected busy 0 state 0", busy, cubestate); end
    send_frame(w1, -1);
    tick(4);
    vectors++; if (nvalid - v0 !== 1 || cubestate !== w1[CUBESTATE_W-1:0]) begin
      errors++; $display("FAIL midreset_recover: got %0d valid state %h expected 1 valid state %h", nvalid - v0, cubestate, w1[CUBESTATE_W-1:0]); end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_solved;
    test_glitch;
    test_bad_stop;
    test_checksum;
    test_timeout;
    test_back_to_back;
    vectors++; if (multi !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", multi); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
